// File: rtl/decode_stage_pkg.sv
// -----------------------------------------------------------------------------
// decode_stage_pkg
// Shared definitions for the CPU32 decode stage: opcode/funct constants,
// ALU control encodings, control-path (cpath) bit positions and the
// instruction field slice positions. Also provides a helper that packs the
// individual control fields into the 10-bit cpath vector.
// -----------------------------------------------------------------------------
package decode_stage_pkg;

    // Control path layout:
    // {reg_wr, reg_dst, alu_src, alu_ctrl[2:0], mem_rd, mem_wr, branch, jump}
    localparam int CPATH_W    = 10;
    localparam int CP_REG_WR  = 9;
    localparam int CP_REG_DST = 8;
    localparam int CP_ALU_SRC = 7;
    localparam int CP_ALU_MSB = 6;
    localparam int CP_ALU_LSB = 4;
    localparam int CP_MEM_RD  = 3;
    localparam int CP_MEM_WR  = 2;
    localparam int CP_BRANCH  = 1;
    localparam int CP_JUMP    = 0;

    // Instruction field slices
    localparam int OP_MSB     = 31;
    localparam int OP_LSB     = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;
    localparam int TGT_MSB    = 25;
    localparam int TGT_LSB    = 0;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_ctrl_e;

    // How the immediate output is formed from the instruction word
    typedef enum logic [1:0] {
        EXT_NONE   = 2'd0,
        EXT_SIGN   = 2'd1,
        EXT_ZERO   = 2'd2,
        EXT_TARGET = 2'd3
    } imm_ext_e;

    function automatic logic [CPATH_W-1:0] pack_cpath(
        input logic      reg_wr,
        input logic      reg_dst,
        input logic      alu_src,
        input alu_ctrl_e alu,
        input logic      mem_rd,
        input logic      mem_wr,
        input logic      branch,
        input logic      jump
    );
        return {reg_wr, reg_dst, alu_src, alu, mem_rd, mem_wr, branch, jump};
    endfunction

endpackage

// File: rtl/decode_stage_inst_decode.sv
// -----------------------------------------------------------------------------
// inst_decode
// Purely combinational CPU32 instruction decoder.
// Ports:
//   inst     in  32      instruction word
//   cpath    out 10      control path {reg_wr,reg_dst,alu_src,alu_ctrl,mem_rd,
//                        mem_wr,branch,jump}; zero for undefined encodings
//   wreg     out 5       destination register (rd if reg_dst, else rt)
//   imm      out XLEN    extended immediate (or zero-extended jump target)
//   illegal  out 1       undefined opcode, or undefined funct under op 0
//   reads_rt out 1       instruction uses rt as a source (R-type, sw, beq)
// -----------------------------------------------------------------------------
module inst_decode
    import decode_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]        inst,
    output logic [CPATH_W-1:0] cpath,
    output logic [4:0]         wreg,
    output logic [XLEN-1:0]    imm,
    output logic               illegal,
    output logic               reads_rt
);

    logic [5:0]  op_s;
    logic [5:0]  funct_s;
    logic [4:0]  rt_s;
    logic [4:0]  rd_s;
    logic [15:0] imm16_s;
    logic [25:0] target_s;
    imm_ext_e    ext_s;

    assign op_s     = inst[OP_MSB:OP_LSB];
    assign funct_s  = inst[FUNCT_MSB:FUNCT_LSB];
    assign rt_s     = inst[RT_MSB:RT_LSB];
    assign rd_s     = inst[RD_MSB:RD_LSB];
    assign imm16_s  = inst[IMM_MSB:IMM_LSB];
    assign target_s = inst[TGT_MSB:TGT_LSB];

    // Opcode/funct to control-path, extension mode and legality
    always_comb begin
        cpath    = {CPATH_W{1'b0}};
        ext_s    = EXT_NONE;
        illegal  = 1'b0;
        reads_rt = 1'b0;
        case (op_s)
            OP_RTYPE: begin
                reads_rt = 1'b1;
                case (funct_s)
                    FN_ADD:  cpath = pack_cpath(1'b1, 1'b1, 1'b0, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
                    FN_SUB:  cpath = pack_cpath(1'b1, 1'b1, 1'b0, ALU_SUB, 1'b0, 1'b0, 1'b0, 1'b0);
                    FN_AND:  cpath = pack_cpath(1'b1, 1'b1, 1'b0, ALU_AND, 1'b0, 1'b0, 1'b0, 1'b0);
                    FN_OR:   cpath = pack_cpath(1'b1, 1'b1, 1'b0, ALU_OR,  1'b0, 1'b0, 1'b0, 1'b0);
                    FN_SLT:  cpath = pack_cpath(1'b1, 1'b1, 1'b0, ALU_SLT, 1'b0, 1'b0, 1'b0, 1'b0);
                    default: illegal = 1'b1;
                endcase
            end
            OP_ADDI: begin
                cpath = pack_cpath(1'b1, 1'b0, 1'b1, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
                ext_s = EXT_SIGN;
            end
            OP_ANDI: begin
                cpath = pack_cpath(1'b1, 1'b0, 1'b1, ALU_AND, 1'b0, 1'b0, 1'b0, 1'b0);
                ext_s = EXT_ZERO;
            end
            OP_ORI: begin
                cpath = pack_cpath(1'b1, 1'b0, 1'b1, ALU_OR, 1'b0, 1'b0, 1'b0, 1'b0);
                ext_s = EXT_ZERO;
            end
            OP_LW: begin
                cpath = pack_cpath(1'b1, 1'b0, 1'b1, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
                ext_s = EXT_SIGN;
            end
            OP_SW: begin
                cpath    = pack_cpath(1'b0, 1'b0, 1'b1, ALU_ADD, 1'b0, 1'b1, 1'b0, 1'b0);
                ext_s    = EXT_SIGN;
                reads_rt = 1'b1;
            end
            OP_BEQ: begin
                cpath    = pack_cpath(1'b0, 1'b0, 1'b0, ALU_SUB, 1'b0, 1'b0, 1'b1, 1'b0);
                ext_s    = EXT_SIGN;
                reads_rt = 1'b1;
            end
            OP_J: begin
                cpath = pack_cpath(1'b0, 1'b0, 1'b0, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b1);
                ext_s = EXT_TARGET;
            end
            default: illegal = 1'b1;
        endcase
    end

    // Destination register select; undefined encodings fall back to rt
    always_comb begin
        if (cpath[CP_REG_DST]) begin
            wreg = rd_s;
        end else begin
            wreg = rt_s;
        end
    end

    // Immediate formation; R-type and undefined encodings carry zero
    always_comb begin
        case (ext_s)
            EXT_SIGN:   imm = {{(XLEN-16){imm16_s[15]}}, imm16_s};
            EXT_ZERO:   imm = {{(XLEN-16){1'b0}}, imm16_s};
            EXT_TARGET: imm = {{(XLEN-26){1'b0}}, target_s};
            default:    imm = {XLEN{1'b0}};
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
// Registered CPU32 decode stage between fetch and execute. Wraps inst_decode
// with a one-entry valid/ready output register, synchronous flush, load-use
// hazard stall insertion and a saturating stall-cycle counter.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous kill; empties the stage, accepts nothing
//   in_valid/in_ready     fetch handshake (in_ready is combinational)
//   in_inst, in_pc        instruction word and its PC
//   out_valid/out_ready   execute handshake
//   out_cpath             {reg_wr,reg_dst,alu_src,alu_ctrl[2:0],mem_rd,mem_wr,
//                          branch,jump}
//   out_rs/out_rt/out_wreg register indices of the held bundle
//   out_imm, out_pc       extended immediate and PC of the held bundle
//   out_illegal           undefined opcode/funct
//   stall_cnt             hazard stall cycles, saturating at all-ones
// -----------------------------------------------------------------------------
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int STALL_CNT_W = 16,
    parameter int HAZARD_EN   = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_inst,
    input  logic [XLEN-1:0]        in_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CPATH_W-1:0]     out_cpath,
    output logic [4:0]             out_rs,
    output logic [4:0]             out_rt,
    output logic [4:0]             out_wreg,
    output logic [XLEN-1:0]        out_imm,
    output logic [XLEN-1:0]        out_pc,
    output logic                   out_illegal,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam logic HAZ_ON = (HAZARD_EN != 0);
    localparam logic [STALL_CNT_W-1:0] CNT_MAX = {STALL_CNT_W{1'b1}};

    logic [CPATH_W-1:0]     dec_cpath_s;
    logic [4:0]             dec_wreg_s;
    logic [XLEN-1:0]        dec_imm_s;
    logic                   dec_illegal_s;
    logic                   dec_reads_rt_s;
    logic [4:0]             in_rs_s;
    logic [4:0]             in_rt_s;
    logic                   hazard_s;
    logic                   accept_s;

    logic                   out_valid_d,   out_valid_q;
    logic [CPATH_W-1:0]     out_cpath_d,   out_cpath_q;
    logic [4:0]             out_rs_d,      out_rs_q;
    logic [4:0]             out_rt_d,      out_rt_q;
    logic [4:0]             out_wreg_d,    out_wreg_q;
    logic [XLEN-1:0]        out_imm_d,     out_imm_q;
    logic [XLEN-1:0]        out_pc_d,      out_pc_q;
    logic                   out_illegal_d, out_illegal_q;
    logic [STALL_CNT_W-1:0] stall_cnt_d,   stall_cnt_q;

    inst_decode #(
        .XLEN (XLEN)
    ) u_inst_decode (
        .inst     (in_inst),
        .cpath    (dec_cpath_s),
        .wreg     (dec_wreg_s),
        .imm      (dec_imm_s),
        .illegal  (dec_illegal_s),
        .reads_rt (dec_reads_rt_s)
    );

    assign in_rs_s = in_inst[RS_MSB:RS_LSB];
    assign in_rt_s = in_inst[RT_MSB:RT_LSB];

    // Load-use detection: a held load whose result the incoming instruction reads
    always_comb begin
        hazard_s = HAZ_ON && out_valid_q && out_cpath_q[CP_MEM_RD] &&
                   (out_wreg_q != 5'd0) && in_valid &&
                   ((in_rs_s == out_wreg_q) ||
                    (dec_reads_rt_s && (in_rt_s == out_wreg_q)));
    end

    // Upstream ready is independent of in_valid except through the hazard term,
    // which only asserts when in_valid is high and thus cannot create a loop
    always_comb begin
        in_ready = !flush && !hazard_s && (!out_valid_q || out_ready);
        accept_s = in_valid && in_ready;
    end

    // Output register next state: flush > accept > drain > hold
    always_comb begin
        out_valid_d   = out_valid_q;
        out_cpath_d   = out_cpath_q;
        out_rs_d      = out_rs_q;
        out_rt_d      = out_rt_q;
        out_wreg_d    = out_wreg_q;
        out_imm_d     = out_imm_q;
        out_pc_d      = out_pc_q;
        out_illegal_d = out_illegal_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept_s) begin
            out_valid_d   = 1'b1;
            out_cpath_d   = dec_cpath_s;
            out_rs_d      = in_rs_s;
            out_rt_d      = in_rt_s;
            out_wreg_d    = dec_wreg_s;
            out_imm_d     = dec_imm_s;
            out_pc_d      = in_pc;
            out_illegal_d = dec_illegal_s;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Stall counter: one count per hazard cycle, ignored while flushing
    always_comb begin
        if (hazard_s && !flush && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            out_cpath_q   <= {CPATH_W{1'b0}};
            out_rs_q      <= 5'd0;
            out_rt_q      <= 5'd0;
            out_wreg_q    <= 5'd0;
            out_imm_q     <= {XLEN{1'b0}};
            out_pc_q      <= {XLEN{1'b0}};
            out_illegal_q <= 1'b0;
            stall_cnt_q   <= {STALL_CNT_W{1'b0}};
        end else begin
            out_valid_q   <= out_valid_d;
            out_cpath_q   <= out_cpath_d;
            out_rs_q      <= out_rs_d;
            out_rt_q      <= out_rt_d;
            out_wreg_q    <= out_wreg_d;
            out_imm_q     <= out_imm_d;
            out_pc_q      <= out_pc_d;
            out_illegal_q <= out_illegal_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_cpath   = out_cpath_q;
    assign out_rs      = out_rs_q;
    assign out_rt      = out_rt_q;
    assign out_wreg    = out_wreg_q;
    assign out_imm     = out_imm_q;
    assign out_pc      = out_pc_q;
    assign out_illegal = out_illegal_q;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage
// Self-checking bench for decode_stage: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model of the stage.
// A second instance with HAZARD_EN=0 checks that load-use pairs issue freely.
// -----------------------------------------------------------------------------
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    // Main instance (hazard detection on)
    logic        flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [31:0] in_inst, in_pc, out_imm, out_pc;
    logic [9:0]  out_cpath;
    logic [4:0]  out_rs, out_rt, out_wreg;
    logic [15:0] stall_cnt;

    // Second instance (hazard detection off)
    logic        n_flush, n_in_valid, n_in_ready, n_out_valid, n_out_ready, n_out_illegal;
    logic [31:0] n_in_inst, n_in_pc, n_out_imm, n_out_pc;
    logic [9:0]  n_out_cpath;
    logic [4:0]  n_out_rs, n_out_rt, n_out_wreg;
    logic [15:0] n_stall_cnt;

    decode_stage #(.XLEN(32), .STALL_CNT_W(16), .HAZARD_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_cpath(out_cpath), .out_rs(out_rs), .out_rt(out_rt), .out_wreg(out_wreg),
        .out_imm(out_imm), .out_pc(out_pc), .out_illegal(out_illegal), .stall_cnt(stall_cnt)
    );

    decode_stage #(.XLEN(32), .STALL_CNT_W(16), .HAZARD_EN(0)) dut_nh (
        .clk(clk), .rst_n(rst_n), .flush(n_flush), .in_valid(n_in_valid), .in_ready(n_in_ready),
        .in_inst(n_in_inst), .in_pc(n_in_pc), .out_valid(n_out_valid), .out_ready(n_out_ready),
        .out_cpath(n_out_cpath), .out_rs(n_out_rs), .out_rt(n_out_rt), .out_wreg(n_out_wreg),
        .out_imm(n_out_imm), .out_pc(n_out_pc), .out_illegal(n_out_illegal), .stall_cnt(n_stall_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct {
        logic [9:0]  cpath;
        logic [4:0]  rs, rt, wreg;
        logic [31:0] imm, pc;
        logic        illegal;
        logic        reads_rt;
    } bundle_t;

    bundle_t     m_b;
    logic        m_valid;
    logic [15:0] m_stall;
    logic        last_ready;
    logic        last_acc;

    function automatic bundle_t ref_decode(input logic [31:0] inst, input logic [31:0] pc);
        bundle_t b;
        int op, fn, alu, sx;
        bit rw, rd_sel, asrc, mrd, mwr, br, jmp, bad;
        int ext; // 0 none, 1 sign, 2 zero, 3 jump target
        op = int'(inst[31:26]); fn = int'(inst[5:0]);
        rw = 0; rd_sel = 0; asrc = 0; mrd = 0; mwr = 0; br = 0; jmp = 0; bad = 0;
        alu = 0; ext = 0;
        if (op == 0) begin
            rw = 1; rd_sel = 1;
            if      (fn == 32) alu = 0;
            else if (fn == 34) alu = 1;
            else if (fn == 36) alu = 2;
            else if (fn == 37) alu = 3;
            else if (fn == 42) alu = 4;
            else begin bad = 1; rw = 0; rd_sel = 0; end
        end
        else if (op == 8)  begin rw = 1; asrc = 1; ext = 1; end
        else if (op == 12) begin rw = 1; asrc = 1; alu = 2; ext = 2; end
        else if (op == 13) begin rw = 1; asrc = 1; alu = 3; ext = 2; end
        else if (op == 35) begin rw = 1; asrc = 1; mrd = 1; ext = 1; end
        else if (op == 43) begin asrc = 1; mwr = 1; ext = 1; end
        else if (op == 4)  begin alu = 1; br = 1; ext = 1; end
        else if (op == 2)  begin jmp = 1; ext = 3; end
        else bad = 1;
        b.cpath   = {rw, rd_sel, asrc, alu[2:0], mrd, mwr, br, jmp};
        b.rs      = inst[25:21];
        b.rt      = inst[20:16];
        b.wreg    = rd_sel ? inst[15:11] : inst[20:16];
        sx        = (inst[15] == 1'b1) ? int'(inst[15:0]) - 65536 : int'(inst[15:0]);
        b.imm     = (ext == 1) ? 32'(sx) :
                    (ext == 2) ? {16'd0, inst[15:0]} :
                    (ext == 3) ? {6'd0, inst[25:0]} : 32'd0;
        b.pc      = pc;
        b.illegal = bad;
        b.reads_rt = (op == 0) || (op == 43) || (op == 4);
        return b;
    endfunction

    task automatic check_outputs();
        check_eq("out_valid", 64'(out_valid), 64'(m_valid));
        if (m_valid) begin
            check_eq("out_cpath",   64'(out_cpath),   64'(m_b.cpath));
            check_eq("out_rs",      64'(out_rs),      64'(m_b.rs));
            check_eq("out_rt",      64'(out_rt),      64'(m_b.rt));
            check_eq("out_wreg",    64'(out_wreg),    64'(m_b.wreg));
            check_eq("out_imm",     64'(out_imm),     64'(m_b.imm));
            check_eq("out_pc",      64'(out_pc),      64'(m_b.pc));
            check_eq("out_illegal", 64'(out_illegal), 64'(m_b.illegal));
        end
        check_eq("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    endtask

    // One clock cycle on the main instance; called just after a falling edge
    task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                        input logic ordy, input logic fl);
        bundle_t d;
        logic haz, exp_rdy;
        in_valid = v; in_inst = inst; in_pc = pc; out_ready = ordy; flush = fl;
        #1;
        d = ref_decode(inst, pc);
        haz = m_valid && m_b.cpath[3] && (m_b.wreg != 5'd0) && v &&
              ((d.rs == m_b.wreg) || (d.reads_rt && (d.rt == m_b.wreg)));
        exp_rdy = !fl && !haz && (!m_valid || ordy);
        check_eq("in_ready", 64'(in_ready), 64'(exp_rdy));
        last_ready = in_ready;
        last_acc   = v && exp_rdy;
        @(posedge clk);
        if (haz && !fl && (m_stall != 16'hFFFF)) m_stall = m_stall + 16'd1;
        if (fl)            m_valid = 1'b0;
        else if (last_acc) begin m_valid = 1'b1; m_b = d; end
        else if (m_valid && ordy) m_valid = 1'b0;
        @(negedge clk);
        check_outputs();
    endtask

    function automatic logic [31:0] rand_inst();
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic [5:0]  fn;
        int k;
        rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3));
        rd = 5'($urandom_range(0, 3)); imm = 16'($urandom);
        k = $urandom_range(0, 12);
        case (k)
            0, 1, 2: begin
                case ($urandom_range(0, 6))
                    0: fn = 6'h20; 1: fn = 6'h22; 2: fn = 6'h24; 3: fn = 6'h25;
                    4: fn = 6'h2A; 5: fn = 6'h21; default: fn = 6'h00;
                endcase
                return {6'h00, rs, rt, rd, 5'($urandom), fn};
            end
            3:       return {6'h08, rs, rt, imm};
            4:       return {6'h0C, rs, rt, imm};
            5:       return {6'h0D, rs, rt, imm};
            6, 7, 8: return {6'h23, rs, rt, imm};
            9:       return {6'h2B, rs, rt, imm};
            10:      return {6'h04, rs, rt, imm};
            11:      return {6'h02, 26'($urandom)};
            default: return {6'h3F, rs, rt, imm};
        endcase
    endfunction

    initial begin
        logic [31:0] pc_hold;
        logic [15:0] stall_hold;
        logic [31:0] r_inst, r_pc;
        logic        r_have;

        rst_n = 1'b0;
        flush = 1'b0; in_valid = 1'b0; in_inst = 32'd0; in_pc = 32'd0; out_ready = 1'b0;
        n_flush = 1'b0; n_in_valid = 1'b0; n_in_inst = 32'd0; n_in_pc = 32'd0; n_out_ready = 1'b1;
        m_valid = 1'b0; m_stall = 16'd0; m_b = ref_decode(32'd0, 32'd0);
        last_ready = 1'b0; last_acc = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_cpath",     64'(out_cpath), 64'd0);
        check_eq("rst_imm",       64'(out_imm),   64'd0);
        check_eq("rst_pc",        64'(out_pc),    64'd0);
        check_eq("rst_wreg",      64'(out_wreg),  64'd0);
        check_eq("rst_illegal",   64'(out_illegal), 64'd0);
        check_eq("rst_stall",     64'(stall_cnt), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // addi r8, r0, 5
        step(1'b1, 32'h20080005, 32'h100, 1'b1, 1'b0);
        check_eq("addi_valid", 64'(out_valid), 64'd1);
        check_eq("addi_cpath", 64'(out_cpath), 64'h280);
        check_eq("addi_wreg",  64'(out_wreg),  64'd8);
        check_eq("addi_imm",   64'(out_imm),   64'h5);

        // Sign and zero extension
        step(1'b1, 32'h2008FFFF, 32'h104, 1'b1, 1'b0);
        check_eq("sext_imm", 64'(out_imm), 64'hFFFFFFFF);
        step(1'b1, 32'h3108FFFF, 32'h108, 1'b1, 1'b0);
        check_eq("zext_imm", 64'(out_imm), 64'h0000FFFF);
        check_eq("andi_alu", 64'(out_cpath[6:4]), 64'd2);

        // Load-use: lw r9 then add r10,r9,r9
        step(1'b1, 32'h8D090000, 32'h10C, 1'b1, 1'b0);
        step(1'b1, 32'h01295020, 32'h110, 1'b1, 1'b0);
        check_eq("lu_ready",  64'(last_ready), 64'd0);
        check_eq("lu_bubble", 64'(out_valid),  64'd0);
        check_eq("lu_stall",  64'(stall_cnt),  64'd1);
        step(1'b1, 32'h01295020, 32'h110, 1'b1, 1'b0);
        check_eq("lu_ready2", 64'(last_ready), 64'd1);
        check_eq("add_wreg",  64'(out_wreg),   64'd10);
        check_eq("add_alu",   64'(out_cpath[6:4]), 64'd0);
        check_eq("add_cpath", 64'(out_cpath),  64'h300);

        // Backpressure for three cycles
        step(1'b1, 32'h350B1234, 32'h114, 1'b1, 1'b0);
        pc_hold = out_pc; stall_hold = stall_cnt;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h200C0001, 32'h118, 1'b0, 1'b0);
            check_eq("bp_ready", 64'(last_ready), 64'd0);
            check_eq("bp_pc",    64'(out_pc),     64'(pc_hold));
            check_eq("bp_valid", 64'(out_valid),  64'd1);
        end
        check_eq("bp_stall", 64'(stall_cnt), 64'(stall_hold));
        step(1'b1, 32'h200C0001, 32'h118, 1'b1, 1'b0);
        check_eq("bp_next_pc", 64'(out_pc), 64'h118);

        // Flush with a valid bundle and a valid input
        step(1'b1, 32'h20100002, 32'h11C, 1'b1, 1'b1);
        check_eq("fl_ready", 64'(last_ready), 64'd0);
        check_eq("fl_valid", 64'(out_valid),  64'd0);

        // Undefined opcode
        step(1'b1, 32'hFC000000, 32'h120, 1'b1, 1'b0);
        check_eq("ill_flag",  64'(out_illegal), 64'd1);
        check_eq("ill_cpath", 64'(out_cpath),   64'd0);

        // Random traffic; an offered instruction is held until accepted
        r_have = 1'b0; r_inst = 32'd0; r_pc = 32'h1000;
        for (int i = 0; i < 600; i++) begin
            if (!r_have || last_acc) begin
                r_have = ($urandom_range(0, 4) != 0);
                r_inst = rand_inst();
                r_pc   = r_pc + 32'd4;
            end
            step(r_have, r_inst, r_pc, ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));
        end

        // Asynchronous reset mid-stream
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        step(1'b1, 32'h20080005, 32'h2000, 1'b0, 1'b0);
        check_eq("pre_rst_valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_valid", 64'(out_valid), 64'd0);
        check_eq("async_rst_stall", 64'(stall_cnt), 64'd0);
        m_valid = 1'b0; m_stall = 16'd0;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // HAZARD_EN=0: lw/add pair issues back-to-back
        n_in_valid = 1'b1; n_in_inst = 32'h8D090000; n_in_pc = 32'h300; n_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("nh_lw_valid", 64'(n_out_valid), 64'd1);
        check_eq("nh_lw_wreg",  64'(n_out_wreg),  64'd9);
        n_in_inst = 32'h01295020; n_in_pc = 32'h304;
        #1;
        check_eq("nh_ready", 64'(n_in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        n_in_valid = 1'b0;
        check_eq("nh_add_valid", 64'(n_out_valid), 64'd1);
        check_eq("nh_add_wreg",  64'(n_out_wreg),  64'd10);
        check_eq("nh_add_pc",    64'(n_out_pc),    64'h304);
        check_eq("nh_stall",     64'(n_stall_cnt), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
